// File: rtl/lfsr_urng.sv
// 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1), STEPS bit-steps per enabled clock.
// Optional lock-up guard against the all-zero state: define LFSR_LOCKUP_GUARD_EN.
module lfsr_urng #(
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter int          STEPS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed_in,
    output logic [31:0] data,
    output logic        valid
);

    logic [31:0] r_state;
    logic        r_valid;
    logic [31:0] w_stepped;
    logic [31:0] w_load_val;
    logic        w_zero;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Unrolled chain of single steps; depth is fixed by STEPS.
    always_comb begin
        w_stepped = r_state;
        for (int i = 0; i < STEPS; i++) begin
            w_stepped = lfsr_step(w_stepped);
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    assign w_load_val = (seed_in == 32'd0) ? SEED : seed_in;
    assign w_zero     = (r_state == 32'd0);
`else
    assign w_load_val = seed_in;
    assign w_zero     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEED;
            r_valid <= 1'b0;
        end else if (load) begin
            r_state <= w_load_val;
            r_valid <= 1'b0;
        end else if (w_zero) begin
            r_state <= SEED;
            r_valid <= 1'b0;
        end else if (enable) begin
            r_state <= w_stepped;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign data  = r_state;
    assign valid = r_valid;

endmodule

// File: tb/tb_lfsr_urng.sv
// Self-checking bench for lfsr_urng: directed steps plus randomized traffic
// compared against an arithmetic reference model.
module tb_lfsr_urng;

    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [31:0] seed_in;
    logic [31:0] data;
    logic        valid;

    logic        enable4;
    logic        load4;
    logic [31:0] seed_in4;
    logic [31:0] data4;
    logic        valid4;

    logic [31:0] m_state;
    logic        m_valid;
    logic [31:0] m_state4;

    int n_pass;
    int n_chk;

    lfsr_urng #(.SEED(SEED), .STEPS(1)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .seed_in(seed_in),
        .data   (data),
        .valid  (valid)
    );

    lfsr_urng #(.SEED(SEED), .STEPS(4)) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable4),
        .load   (load4),
        .seed_in(seed_in4),
        .data   (data4),
        .valid  (valid4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiply-by-two shift with the feedback bit as parity of tapped bits.
    function automatic logic [31:0] ref_adv(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < n; k++) begin
            t = (t << 1) | {31'd0, ^(t & TAPS)};
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic en, input logic ld,
                              input logic [31:0] sd);
        if (ld) begin
`ifdef LFSR_LOCKUP_GUARD_EN
            m_state = (sd == 32'd0) ? SEED : sd;
`else
            m_state = sd;
`endif
            m_valid = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        end else if (m_state == 32'd0) begin
            m_state = SEED;
            m_valid = 1'b0;
`endif
        end else if (en) begin
            m_state = ref_adv(m_state, 1);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic apply(input string tag, input logic en, input logic ld,
                         input logic [31:0] sd);
        @(negedge clk);
        enable  = en;
        load    = ld;
        seed_in = sd;
        model_edge(en, ld, sd);
        @(posedge clk);
        #1;
        chk({tag, ".data"}, data, m_state);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    endtask

    initial begin
        n_pass   = 0;
        n_chk    = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        seed_in  = 32'd0;
        enable4  = 1'b0;
        load4    = 1'b0;
        seed_in4 = 32'd0;
        m_state  = SEED;
        m_valid  = 1'b0;

        @(posedge clk);
        #1;
        chk("reset.data", data, SEED);
        chk("reset.valid", {31'd0, valid}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        apply("first1", 1'b1, 1'b0, 32'd0);
        apply("first2", 1'b1, 1'b0, 32'd0);
        chk("first2.const", data, 32'h0000_0006);

        for (int i = 0; i < 3; i++) apply("gate", 1'b0, 1'b0, 32'd0);
        apply("reen1", 1'b1, 1'b0, 32'd0);
        chk("reen1.const", data, 32'h0000_000D);
        apply("reen2", 1'b1, 1'b0, 32'd0);
        chk("reen2.const", data, 32'h0000_001B);

        apply("ldpri", 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("ldpri.const", data, 32'hDEAD_BEEF);
        apply("ldstep", 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < 200; i++) begin
            apply("rand", ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), $urandom);
        end

        @(negedge clk);
        enable = 1'b1;
        load   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async.data", data, SEED);
        chk("async.valid", {31'd0, valid}, 32'd0);
        chk("async.data4", data4, SEED);
        m_state = SEED;
        m_valid = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        apply("postrst", 1'b1, 1'b0, 32'd0);

        m_state4 = SEED;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            enable4  = 1'b1;
            m_state4 = ref_adv(m_state4, 4);
            @(posedge clk);
            #1;
            chk("multi.data", data4, m_state4);
            chk("multi.valid", {31'd0, valid4}, 32'd1);
            if (i == 0) chk("multi.const", data4, 32'h0000_001B);
        end
        @(negedge clk);
        enable4 = 1'b0;

        apply("lock.load", 1'b0, 1'b1, 32'd0);
`ifdef LFSR_LOCKUP_GUARD_EN
        chk("lock.const", data, SEED);
`else
        chk("lock.const", data, 32'd0);
`endif
        for (int i = 0; i < 5; i++) apply("lock.run", 1'b1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
